// File: rtl/loader_pkg.sv
// Shared definitions for the UART instruction-memory loader: frame FSM
// encoding, default header byte and the bit-period helper.
package loader_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART byte sampler: 2-flop synchronizer, mid-bit start re-check,
// one-cycle byte_valid on a good stop bit, one-cycle frame_err on a bad one.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] ZERO    = {CW{1'b0}};
  localparam logic [CW-1:0] ONE     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] SMP_IDLE  = 2'd0;
  localparam logic [1:0] SMP_START = 2'd1;
  localparam logic [1:0] SMP_DATA  = 2'd2;
  localparam logic [1:0] SMP_STOP  = 2'd3;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_prev;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_valid;
  logic [7:0]    r_data;
  logic          r_ferr;

  // Synchronizer, edge history and the bit-sampling state machine.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_prev    <= 1'b1;
      r_state   <= SMP_IDLE;
      r_cnt     <= ZERO;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_valid   <= 1'b0;
      r_data    <= 8'h00;
      r_ferr    <= 1'b0;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        SMP_IDLE: begin
          if (r_prev && !r_sync2) begin
            r_state <= SMP_START;
            r_cnt   <= HALF_M1;
          end
        end
        SMP_START: begin
          if (r_cnt == ZERO) begin
            // A line that is high again at mid-start was a glitch.
            if (r_sync2) begin
              r_state <= SMP_IDLE;
            end else begin
              r_state   <= SMP_DATA;
              r_cnt     <= FULL_M1;
              r_bit_idx <= 3'd0;
            end
          end else begin
            r_cnt <= r_cnt - ONE;
          end
        end
        SMP_DATA: begin
          if (r_cnt == ZERO) begin
            r_shift <= {r_sync2, r_shift[7:1]};
            r_cnt   <= FULL_M1;
            if (r_bit_idx == 3'd7) begin
              r_state <= SMP_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt - ONE;
          end
        end
        SMP_STOP: begin
          if (r_cnt == ZERO) begin
            r_state <= SMP_IDLE;
            if (r_sync2) begin
              r_valid <= 1'b1;
              r_data  <= r_shift;
            end else begin
              r_ferr <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - ONE;
          end
        end
        default: begin
          r_state <= SMP_IDLE;
        end
      endcase
    end
  end

  assign byte_valid = r_valid;
  assign byte_data  = r_data;
  assign frame_err  = r_ferr;

endmodule

// File: rtl/im_loader.sv
// Serial boot loader: receives HDR, a word count and little-endian words over
// UART and writes them to instruction memory from address 0 upward.
module im_loader
  import loader_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int unsigned BAUD   = 115200,
  parameter logic [7:0]  HDR    = HDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

  logic        w_byte_valid;
  logic [7:0]  w_byte_data;
  logic        w_frame_err;

  logic [2:0]  r_state;
  logic [8:0]  r_remain;
  logic [31:0] r_addr_cnt;
  logic [1:0]  r_byte_idx;
  logic [23:0] r_word;
  logic        r_im_we;
  logic [31:0] r_im_addr;
  logic [31:0] r_im_wdata;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .byte_valid(w_byte_valid),
    .byte_data (w_byte_data),
    .frame_err (w_frame_err)
  );

  // Frame FSM with registered write strobe, address, data and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_remain   <= 9'd0;
      r_addr_cnt <= 32'h0000_0000;
      r_byte_idx <= 2'd0;
      r_word     <= 24'h00_0000;
      r_im_we    <= 1'b0;
      r_im_addr  <= 32'h0000_0000;
      r_im_wdata <= 32'h0000_0000;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_im_we <= 1'b0;
      r_done  <= 1'b0;
      if (w_frame_err) begin
        r_err   <= 1'b1;
        r_busy  <= 1'b0;
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_byte_valid && (w_byte_data == HDR)) begin
              r_state <= S_LEN;
              r_busy  <= 1'b1;
              r_err   <= 1'b0;
            end
          end
          S_LEN: begin
            if (w_byte_valid) begin
              r_remain   <= (w_byte_data == 8'h00) ? 9'd256 : {1'b0, w_byte_data};
              r_addr_cnt <= 32'h0000_0000;
              r_byte_idx <= 2'd0;
              r_state    <= S_DATA;
            end
          end
          S_DATA: begin
            if (w_byte_valid) begin
              case (r_byte_idx)
                2'd0: r_word[7:0]   <= w_byte_data;
                2'd1: r_word[15:8]  <= w_byte_data;
                2'd2: r_word[23:16] <= w_byte_data;
                default: begin
                  // Fourth byte completes the word; strobe goes out next cycle.
                  r_im_wdata <= {w_byte_data, r_word};
                  r_im_addr  <= r_addr_cnt;
                  r_im_we    <= 1'b1;
                  r_state    <= S_WRITE;
                end
              endcase
              r_byte_idx <= r_byte_idx + 2'd1;
            end
          end
          S_WRITE: begin
            r_addr_cnt <= r_addr_cnt + 32'd4;
            r_remain   <= r_remain - 9'd1;
            if (r_remain == 9'd1) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_DATA;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign im_we    = r_im_we;
  assign im_addr  = r_im_addr;
  assign im_wdata = r_im_wdata;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: byte-level reference model queues expected
// writes/done pulses; a negedge monitor pops and compares them.
module tb_im_loader;

  localparam int CPB = 10;
  localparam int GAP = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx  = 1'b1;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  im_loader #(
    .CLK_HZ(1000000),
    .BAUD  (100000),
    .HDR   (8'hA5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .im_we   (im_we),
    .im_addr (im_addr),
    .im_wdata(im_wdata),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int n_cmp = 0;
  int n_bad = 0;
  wr_t exp_wr[$];
  int exp_done = 0;
  int cyc = 0;
  int last_we_cyc = -10;

  // Reference model state, at the level of frames and bytes.
  int         m_mode = 0;
  int         m_rem  = 0;
  logic [31:0] m_addr = 32'h0;
  logic [7:0] m_bytes[$];
  bit         m_busy = 1'b0;
  bit         m_err  = 1'b0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_mode = 0;
    m_busy = 1'b0;
    m_err  = 1'b0;
    m_bytes.delete();
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit stop_ok);
    wr_t w;
    if (!stop_ok) begin
      m_err  = 1'b1;
      m_busy = 1'b0;
      m_mode = 0;
      return;
    end
    case (m_mode)
      0: if (b == 8'hA5) begin m_mode = 1; m_busy = 1'b1; m_err = 1'b0; end
      1: begin
        m_rem  = (b == 8'h00) ? 256 : int'(b);
        m_addr = 32'h0;
        m_bytes.delete();
        m_mode = 2;
      end
      default: begin
        m_bytes.push_back(b);
        if (m_bytes.size() == 4) begin
          w.addr = m_addr;
          w.data = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
          exp_wr.push_back(w);
          m_addr = m_addr + 32'd4;
          m_bytes.delete();
          m_rem--;
          if (m_rem == 0) begin
            exp_done++;
            m_mode = 0;
            m_busy = 1'b0;
          end
        end
      end
    endcase
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: every write strobe and done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (im_we) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_we", 64'd1, 64'd0);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("im_addr", {32'h0, im_addr}, {32'h0, w.addr});
          check("im_wdata", {32'h0, im_wdata}, {32'h0, w.data});
        end
        last_we_cyc = cyc;
      end
      if (done) begin
        check("done_expected", 64'(exp_done > 0), 64'd1);
        check("done_latency", 64'(cyc - last_we_cyc), 64'd1);
        check("busy_at_done", {63'h0, busy}, 64'd0);
        if (exp_done > 0) exp_done--;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
    model_byte(b, stop_ok);
    @(negedge clk) rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (GAP) @(negedge clk);
    check("busy", {63'h0, busy}, {63'h0, m_busy});
    check("err", {63'h0, err}, {63'h0, m_err});
  endtask

  task automatic glitch();
    @(negedge clk) rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_busy", {63'h0, busy}, {63'h0, m_busy});
    check("glitch_err", {63'h0, err}, {63'h0, m_err});
  endtask

  task automatic drain();
    repeat (20) @(negedge clk);
    check("writes_drained", 64'(exp_wr.size()), 64'd0);
    check("done_drained", 64'(exp_done), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int n;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_we", {63'h0, im_we}, 64'd0);
    check("rst_addr", {32'h0, im_addr}, 64'd0);
    check("rst_wdata", {32'h0, im_wdata}, 64'd0);
    check("rst_flags", {61'h0, busy, done, err}, 64'd0);
    @(negedge clk) rst = 1'b1;
    repeat (5) @(negedge clk);

    // Single word.
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    drain();

    // Two words.
    send_byte(8'hA5); send_byte(8'h02);
    for (int i = 1; i <= 8; i++) send_byte(8'((i << 4) | i));
    drain();

    // Leading junk, header value inside the data.
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    drain();

    // Framing error mid-frame, then recovery.
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h5A, 1'b0);
    send_byte(8'hA5);
    send_byte(8'h01); send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    drain();

    // Glitches while idle and inside a word.
    glitch();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
    glitch();
    send_byte(8'h20); send_byte(8'h30); send_byte(8'h40);
    drain();

    // Reset after two data bytes.
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h77); send_byte(8'h66);
    @(negedge clk) rst = 1'b0;
    model_reset();
    #1;
    check("midrst_we", {63'h0, im_we}, 64'd0);
    check("midrst_addr", {32'h0, im_addr}, 64'd0);
    check("midrst_wdata", {32'h0, im_wdata}, 64'd0);
    check("midrst_flags", {61'h0, busy, done, err}, 64'd0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'h0D); send_byte(8'hF0); send_byte(8'hAD); send_byte(8'h0B);
    drain();

    // Randomized frames with junk and occasional framing errors.
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(0, 2);
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        send_byte(b);
      end
      send_byte(8'hA5);
      n = $urandom_range(1, 3);
      send_byte(8'(n));
      for (int j = 0; j < 4 * n; j++) begin
        if ($urandom_range(0, 19) == 0) begin
          send_byte(8'($urandom), 1'b0);
          break;
        end
        send_byte(8'($urandom));
      end
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
